// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch/decode constants and fetch FSM state type
package riscv_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding fetched {pc, word} entries
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push in the same cycle its head leaves
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Entry storage; contents are don't-care until count says otherwise
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush wins over any push/pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch unit: PC, imem requests, fetch buffer, redirects; INSTR_ALIGN_CHK_EN enables misaligned-redirect trap
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int                WIDTH      = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_re,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WIDTH-1:0]  imem_rdata,
    output logic [WIDTH-1:0]  opcode,
    output logic [ADDR_W-1:0] pc_out,
    output logic              valid,
    input  logic              ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_misaligned
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + WIDTH;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] pc_hold;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              inflight;
    logic              misalign;
    logic              head_valid;
    logic              pop;
    logic              push;
    logic [ENT_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;

`ifdef INSTR_ALIGN_CHK_EN
    assign misalign     = redirect && (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc;
`else
    assign misalign     = 1'b0;
    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
`endif

    assign head_valid = !fifo_empty && (state != S_TRAP);
    assign pop        = head_valid && ready;
    // Slots already claimed once this cycle's pop is taken into account
    assign occupancy  = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    // A response still in flight during a redirect is dropped by the flush
    assign push       = inflight;

    assign imem_addr = pc;
    assign opcode    = head_valid ? head[WIDTH-1:0] : WIDTH'(NOP_INSTR);
    assign pc_out    = head_valid ? head[ENT_W-1:WIDTH] : pc_hold;

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({req_pc, imem_rdata}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_BOOT;
        else     state <= next_state;
    end

    // FSM next state: boot lasts one cycle, trap is only left through reset
    always_comb begin
        next_state = state;
        case (state)
            S_BOOT:  next_state = misalign ? S_TRAP : S_RUN;
            S_RUN:   if (misalign) next_state = S_TRAP;
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_BOOT;
        endcase
    end

    // FSM outputs: issue only while running, with room and no redirect
    always_comb begin
        imem_re          = 1'b0;
        valid            = head_valid;
        fetch_misaligned = 1'b0;
        case (state)
            S_RUN:   imem_re = !redirect && (occupancy < DEPTH_C);
`ifdef INSTR_ALIGN_CHK_EN
            S_TRAP:  fetch_misaligned = 1'b1;
`endif
            default: imem_re = 1'b0;
        endcase
    end

    // PC, outstanding request tracking, and last presented pc for idle output
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            pc_hold  <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_re;
            if (imem_re) begin
                pc     <= pc + ADDR_W'(4);
                req_pc <= pc;
            end
            if (redirect) pc <= redirect_tgt;
            if (head_valid) pc_hold <= head[ENT_W-1:WIDTH];
        end
    end

    // The issue rule must never let a response land in a full FIFO without a pop
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full && !pop));
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with directed and random stimulus
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_re;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic [31:0] opcode;
    logic [31:0] pc_out;
    logic        valid;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_misaligned;

    int n_pass  = 0;
    int n_total = 0;
    int n_hs    = 0;
    bit mon_en  = 1'b0;
    bit rst_s   = 1'b0;
    bit trapped = 1'b0;
    logic [31:0] exp_q[$];

    instr_fetch #(
        .WIDTH      (32),
        .ADDR_W     (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_re          (imem_re),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .opcode           (opcode),
        .pc_out           (pc_out),
        .valid            (valid),
        .ready            (ready),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency, garbage when not read
    always @(posedge clk) begin
        imem_rdata <= imem_re ? (32'hA000_0000 | imem_addr) : 32'hDEAD_BEEF;
        rst_s <= rst;
        if (rst) mon_en <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic restart(input logic [31:0] base);
        exp_q.delete();
        exp_q.push_back(base);
    endtask

    // Monitor: expected stream is base, base+4, ... restarted on reset/redirect
    always @(negedge clk) begin
        logic [31:0] junk;
        if (mon_en) begin
            if (rst_s) begin
                check("rst_valid", valid, 0);
                check("rst_opcode", opcode, 32'h0000_0013);
                check("rst_pc_out", pc_out, 0);
                check("rst_imem_re", imem_re, 0);
                check("rst_imem_addr", imem_addr, 0);
                check("rst_misaligned", fetch_misaligned, 0);
            end else if (trapped) begin
                check("trap_misaligned", fetch_misaligned, 1);
                check("trap_imem_re", imem_re, 0);
                check("trap_valid", valid, 0);
            end else begin
                check("misaligned_low", fetch_misaligned, 0);
                if (valid) begin
                    while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
                    check("head_pc", pc_out, exp_q[0]);
                    check("head_word", opcode, 32'hA000_0000 | exp_q[0]);
                    if (ready) begin
                        junk = exp_q.pop_front();
                        n_hs++;
                    end
                end else begin
                    check("idle_nop", opcode, 32'h0000_0013);
                end
            end
            if (rst) begin
                restart(32'h0);
                trapped = 1'b0;
            end else if (redirect && !trapped) begin
`ifdef INSTR_ALIGN_CHK_EN
                if (redirect_pc[1:0] != 2'b00) begin
                    trapped = 1'b1;
                    restart(32'h0);
                end else begin
                    restart(redirect_pc);
                end
`else
                restart(redirect_pc & ~32'd3);
`endif
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // From cycle 0 after reset release: request in cycle 1, valid in cycle 3
    task automatic boot_seq(input string tag);
        sample();
        check({tag, "_c0_re"}, imem_re, 0);
        check({tag, "_c0_valid"}, valid, 0);
        drive_edge(); sample();
        check({tag, "_c1_re"}, imem_re, 1);
        check({tag, "_c1_addr"}, imem_addr, 0);
        drive_edge(); sample();
        check({tag, "_c2_valid"}, valid, 0);
        drive_edge(); sample();
        check({tag, "_c3_valid"}, valid, 1);
        check({tag, "_c3_pc"}, pc_out, 0);
        check({tag, "_c3_op"}, opcode, 32'hA000_0000);
        for (int i = 1; i < 4; i++) begin
            drive_edge(); sample();
            check({tag, "_seq_valid"}, valid, 1);
            check({tag, "_seq_pc"}, pc_out, 4 * i);
        end
    endtask

    initial begin
        logic [31:0] head;
        int hs0;

        // 1) reset and start-up latency
        rst = 1'b1; ready = 1'b1;
        repeat (2) drive_edge();
        rst = 1'b0;
        boot_seq("boot");

        // 2) backpressure
        drive_edge(); ready = 1'b0;
        sample();
        check("bp_valid", valid, 1);
        head = pc_out;
        repeat (5) begin
            drive_edge(); sample();
            check("bp_no_issue", imem_re, 0);
            check("bp_head_stable", pc_out, head);
            check("bp_valid_held", valid, 1);
        end
        drive_edge(); ready = 1'b1; hs0 = n_hs;
        repeat (6) begin sample(); drive_edge(); end
        check("bp_drain_rate", n_hs - hs0, 6);

        // 3) redirect with an entry buffered and a response in flight
        ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        sample();
        check("rd_pre_valid", valid, 1);
        head = pc_out;
        drive_edge(); redirect = 1'b0; ready = 1'b1;
        sample();
        check("rd_r1_valid", valid, 0);
        check("rd_r1_re", imem_re, 1);
        check("rd_r1_addr", imem_addr, 32'h100);
        check("rd_r1_pc_hold", pc_out, head);
        drive_edge(); sample();
        check("rd_r2_valid", valid, 0);
        drive_edge(); sample();
        check("rd_r3_valid", valid, 1);
        check("rd_r3_pc", pc_out, 32'h100);
        check("rd_r3_op", opcode, 32'hA000_0100);

        // 4) redirect in the same cycle as a handshake
        drive_edge(); drive_edge();
        drive_edge(); redirect = 1'b1; redirect_pc = 32'h200; hs0 = n_hs;
        sample();
        check("rdhs_valid", valid, 1);
        drive_edge(); redirect = 1'b0;
        sample(); drive_edge(); sample(); drive_edge();
        check("rdhs_consumed_once", n_hs - hs0, 1);
        sample();
        check("rdhs_pc", pc_out, 32'h200);

        // 5) misaligned redirect target
        drive_edge(); redirect = 1'b1; redirect_pc = 32'h102;
        sample();
        drive_edge(); redirect = 1'b0;
`ifdef INSTR_ALIGN_CHK_EN
        repeat (5) begin
            sample();
            check("mis_flag", fetch_misaligned, 1);
            check("mis_re", imem_re, 0);
            check("mis_valid", valid, 0);
            drive_edge();
        end
        rst = 1'b1;
        drive_edge(); rst = 1'b0;
        boot_seq("trap_exit");
`else
        sample();
        check("mis_re", imem_re, 1);
        check("mis_addr", imem_addr, 32'h100);
        drive_edge(); sample(); drive_edge(); sample();
        check("mis_pc", pc_out, 32'h100);
        check("mis_flag", fetch_misaligned, 0);
`endif

        // 6) reset mid-stream with the FIFO full
        drive_edge(); ready = 1'b0;
        repeat (3) drive_edge();
        sample();
        check("full_no_issue", imem_re, 0);
        check("full_valid", valid, 1);
        drive_edge(); rst = 1'b1; ready = 1'b1;
        drive_edge(); rst = 1'b0;
        boot_seq("mid_rst");

        // Random traffic against the scoreboard
        hs0 = n_hs;
        for (int c = 0; c < 3000; c++) begin
            drive_edge();
            ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom_range(0, 32'hFFFF);
`ifdef INSTR_ALIGN_CHK_EN
            if ($urandom_range(0, 19) != 0) redirect_pc[1:0] = 2'b00;
`endif
        end
        drive_edge();
        rst = 1'b0; redirect = 1'b0; ready = 1'b1;
        drive_edge();
        check("random_progress", (n_hs - hs0) >= 300, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
